tas_pkt_tx: RTL



---
 rtl/tas_pkg.sv | 30 +++
 rtl/tas_sync_fifo.sv | 74 +++++++
 rtl/tas_pkt_tx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tas_pkg.sv
// ----------------------------------------------------------------------------
// tas_pkg
// Shared definitions for the temperature-sample packet transmitter:
//   - tas_tx_state_t      : transmitter FSM state encoding
//   - TAS_HDR_A5/C3       : the two selectable header bytes
//   - TAS_BITS_PER_BYTE   : serial bits per framed byte
//   - TAS_SAMPLES_PER_PKT : samples carried by one packet
//   - tas_hdr_byte()      : maps the header select bit to its header byte
// ----------------------------------------------------------------------------
package tas_pkg;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_HDR  = 3'd1,
        TX_DATA = 3'd2,
        TX_BGAP = 3'd3,
        TX_PGAP = 3'd4
    } tas_tx_state_t;

    localparam logic [7:0] TAS_HDR_A5 = 8'hA5;
    localparam logic [7:0] TAS_HDR_C3 = 8'hC3;

    localparam int TAS_BITS_PER_BYTE   = 8;
    localparam int TAS_SAMPLES_PER_PKT = 4;

    function automatic logic [7:0] tas_hdr_byte(input logic sel);
        return sel ? TAS_HDR_C3 : TAS_HDR_A5;
    endfunction

endpackage

// File: rtl/tas_sync_fifo.sv
// ----------------------------------------------------------------------------
// tas_sync_fifo
// Single-clock show-ahead FIFO: o_rd_data always presents the oldest entry,
// i_rd_en consumes it. Writes when full and reads when empty are ignored.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (flushes contents)
//   i_wr_en/i_wr_data  write request and data
//   i_rd_en          consume the head entry
//   o_rd_data        head entry (valid when !o_empty)
//   o_full, o_empty  occupancy flags
//   o_level          number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module tas_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    // Storage is not reset; only the pointers and level define validity.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/tas_pkt_tx.sv
// ----------------------------------------------------------------------------
// tas_pkt_tx
// Buffers 8-bit temperature samples and, once four are queued, sends a packet
// of header + 4 samples bit-serially, LSB first. Each byte takes a 9-cycle
// slot: 8 cycles with data_ena=1 followed by one idle cycle (BGAP) that lets
// the receiver close the byte. A packet therefore lasts 45 cycles.
//
// Ports:
//   clk_50       clock, all logic on the rising edge
//   reset        synchronous active-high reset; flushes the FIFO
//   s_valid/s_ready/s_data  sample input; a sample is taken when both
//                valid and ready are high at a rising edge. s_ready is
//                !full && !reset and is the only combinational output.
//   hdr_sel      header select (0: 0xA5, 1: 0xC3), sampled at packet start
//   serial_data  serial bit, LSB first; 0 whenever data_ena is low
//   data_ena     high while serial_data carries a bit
//   busy         high from packet start through the end of any trailing gap
//   pkt_sent     one-cycle pulse during the final idle cycle of a packet
//   pkt_count    wrapping count of completed packets
//   fifo_level   current FIFO occupancy
//
// Build option: define TAS_TX_GAP_EN to insert GAP_CYCLES idle (busy) cycles
// after each packet (PGAP state). Without it, packets run back to back.
// ----------------------------------------------------------------------------
module tas_pkt_tx
    import tas_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                          clk_50,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [7:0]                    s_data,
    input  logic                          hdr_sel,
    output logic                          serial_data,
    output logic                          data_ena,
    output logic                          busy,
    output logic                          pkt_sent,
    output logic [15:0]                   pkt_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int         LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_BIT  = 3'(TAS_BITS_PER_BYTE - 1);
    localparam logic [2:0] LAST_BYTE = 3'(TAS_SAMPLES_PER_PKT);

    tas_tx_state_t r_state;
    tas_tx_state_t w_state_nxt;

    logic [2:0]    r_bit_cnt;
    logic [2:0]    r_byte_cnt;
    logic [7:0]    r_shift;
    logic          r_data_ena;
    logic          r_busy;
    logic          r_pkt_sent;
    logic [15:0]   r_pkt_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_fifo_rdata;
    logic [LW-1:0] w_level;

    logic          w_pkt_ready;
    logic          w_last_bit;
    logic          w_last_byte;
    logic          w_gap_done;
    logic          w_start;
    logic          w_load_sample;
    logic [7:0]    w_shift_nxt;
    logic          w_data_ena_nxt;
    logic          w_busy_nxt;
    logic          w_pkt_sent_nxt;

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    assign s_ready = !w_full && !reset;
    assign w_push  = s_valid && s_ready;

    tas_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk_50),
        .i_reset   (reset),
        .i_wr_en   (w_push),
        .i_wr_data (s_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rdata),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    assign w_pkt_ready = (w_level >= LW'(TAS_SAMPLES_PER_PKT));
    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    // ------------------------------------------------------------------
    // Post-packet gap timer
    // ------------------------------------------------------------------
`ifdef TAS_TX_GAP_EN
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [GW-1:0] r_gap_cnt;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_gap_cnt <= '0;
        end else if (r_state == TX_PGAP) begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    assign w_gap_done = (r_gap_cnt == GW'(GAP_CYCLES - 1));
`else
    // PGAP is unreachable in this build.
    assign w_gap_done = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE: begin
                if (w_pkt_ready) begin
                    w_state_nxt = TX_HDR;
                end
            end
            TX_HDR, TX_DATA: begin
                if (w_last_bit) begin
                    w_state_nxt = TX_BGAP;
                end
            end
            TX_BGAP: begin
                if (!w_last_byte) begin
                    w_state_nxt = TX_DATA;
                end else begin
`ifdef TAS_TX_GAP_EN
                    w_state_nxt = TX_PGAP;
`else
                    w_state_nxt = w_pkt_ready ? TX_HDR : TX_IDLE;
`endif
                end
            end
            TX_PGAP: begin
                if (w_gap_done) begin
                    w_state_nxt = w_pkt_ready ? TX_HDR : TX_IDLE;
                end
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Next values of the registered outputs are decoded from
    // the next state so every output is a flop with no extra latency.
    // ------------------------------------------------------------------
    always_comb begin
        w_start       = (w_state_nxt == TX_HDR) && (r_state != TX_HDR);
        w_load_sample = (r_state == TX_BGAP) && (w_state_nxt == TX_DATA);

        // The header select is captured only here, at packet start.
        // Shifting in zeros leaves the register clear for BGAP/IDLE/PGAP,
        // which keeps serial_data low whenever data_ena is low.
        w_shift_nxt = r_shift;
        if (w_start) begin
            w_shift_nxt = tas_hdr_byte(hdr_sel);
        end else if (w_load_sample) begin
            w_shift_nxt = w_fifo_rdata;
        end else if ((r_state == TX_HDR) || (r_state == TX_DATA)) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end

        w_data_ena_nxt = (w_state_nxt == TX_HDR) || (w_state_nxt == TX_DATA);
        w_busy_nxt     = (w_state_nxt != TX_IDLE);
        w_pkt_sent_nxt = (r_state == TX_DATA) && w_last_bit && w_last_byte;

        // The head sample was copied into the shift register on entry to
        // DATA; it is consumed while its bit 0 is on the line.
        w_pop = (r_state == TX_DATA) && (r_bit_cnt == 3'd0) && !w_empty;
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_data_ena  <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_sent  <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_data_ena <= w_data_ena_nxt;
            r_busy     <= w_busy_nxt;
            r_pkt_sent <= w_pkt_sent_nxt;

            if ((r_state == TX_HDR) || (r_state == TX_DATA)) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else begin
                r_bit_cnt <= '0;
            end

            if (w_start) begin
                r_byte_cnt <= '0;
            end else if (w_load_sample) begin
                r_byte_cnt <= r_byte_cnt + 3'd1;
            end

            if (w_pkt_sent_nxt) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign serial_data = r_shift[0];
    assign data_ena    = r_data_ena;
    assign busy        = r_busy;
    assign pkt_sent    = r_pkt_sent;
    assign pkt_count   = r_pkt_count;
    assign fifo_level  = w_level;

endmodule
